// File: rtl/hps_io_pkg.sv
// Shared constants for the HPS general-purpose I/O initiator: FSM state codes,
// channel codes, gp_in/gp_out bit positions, core magic and reset-control encodings.
package hps_io_pkg;

    typedef logic [3:0] state_t;

    localparam state_t ST_MAGIC = 4'd0;
    localparam state_t ST_IDLE  = 4'd1;
    localparam state_t ST_OPEN  = 4'd2;
    localparam state_t ST_SEND  = 4'd3;
    localparam state_t ST_CLKHI = 4'd4;
    localparam state_t ST_ACK1  = 4'd5;
    localparam state_t ST_ACK0  = 4'd6;
    localparam state_t ST_END   = 4'd7;
    localparam state_t ST_RST   = 4'd8;

    localparam logic [1:0] CH_UIO  = 2'd0;
    localparam logic [1:0] CH_FPGA = 2'd1;
    localparam logic [1:0] CH_OSD  = 2'd2;

    localparam int GP_CLK  = 17;
    localparam int GP_FPGA = 18;
    localparam int GP_OSD  = 19;
    localparam int GP_UIO  = 20;
    localparam int GP_ACK  = 17;
    localparam int GP_WIDE = 16;

    localparam logic [31:0] CORE_MAGIC = 32'h5CA6_23A4;

    localparam logic [1:0] CTL_IDLE  = 2'b10;
    localparam logic [1:0] CTL_RST   = 2'b01;
    localparam logic [1:0] CTL_MAGIC = 2'b00;

    // Select vector ordered as gp_out[GP_UIO:GP_FPGA] = {uio, osd, fpga}.
    function automatic logic [2:0] chan_onehot(input logic [1:0] ch);
        case (ch)
            CH_UIO:  return 3'b100;
            CH_FPGA: return 3'b001;
            CH_OSD:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/hps_io_master_delay.sv
// Loadable down-counter shared by the settle, reset-hold and ack-timeout waits.
// done is high while the count sits at zero; loading value N gives N+1 cycles until done.
module hps_io_delay (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] value,
    output logic        done
);

    logic [15:0] cnt_q;
    logic [15:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = value;
        end else if (cnt_q != 16'd0) begin
            cnt_d = cnt_q - 16'd1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == 16'd0);

endmodule

// File: rtl/hps_io_master.sv
// HPS general-purpose I/O bus initiator: magic check, framed word transfers, core reset.
// Optional ack-wait timeout with its 'timeout' port is built when HPS_IO_MASTER_TIMEOUT_EN is defined.
module hps_io_master
    import hps_io_pkg::*;
#(
    parameter int SETTLE   = 4,
    parameter int RST_HOLD = 16,
    parameter int TIMEOUT  = 65535
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic [31:0] gp_in,
    output logic [31:0] gp_out,
    input  logic        start,
    input  logic [1:0]  sel,
    input  logic [15:0] wr_data,
    input  logic        wr_valid,
    input  logic        wr_last,
    output logic        wr_ready,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    input  logic        core_rst_req,
    output logic        busy,
    output logic        magic_ok,
    output logic        wide,
    output logic [1:0]  buttons
`ifdef HPS_IO_MASTER_TIMEOUT_EN
    ,
    output logic        timeout
`endif
);

    localparam logic [15:0] SETTLE_LD = 16'(SETTLE - 1);
    localparam logic [15:0] RST_LD    = 16'(RST_HOLD - 1);
`ifdef HPS_IO_MASTER_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LD = 16'(TIMEOUT - 1);
`else
    localparam int unused_timeout = TIMEOUT;
`endif

    state_t      state_q, state_d;
    logic [1:0]  ctl_q, ctl_d;
    logic [2:0]  chan_q, chan_d;
    logic        io_clk_q, io_clk_d;
    logic [15:0] din_q, din_d;
    logic        last_q, last_d;
    logic        first_q, first_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;
    logic        magic_ok_q, magic_ok_d;
    logic        wide_q, wide_d;
    logic [1:0]  buttons_q, buttons_d;
    logic        timeout_q, timeout_d;
    logic        dly_load;
    logic [15:0] dly_value;
    logic        dly_done;

    hps_io_delay u_delay (
        .clk_sys (clk_sys),
        .reset   (reset),
        .load    (dly_load),
        .value   (dly_value),
        .done    (dly_done)
    );

    always_comb begin
        state_d    = state_q;
        ctl_d      = ctl_q;
        chan_d     = chan_q;
        io_clk_d   = io_clk_q;
        din_d      = din_q;
        last_d     = last_q;
        first_d    = first_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        magic_ok_d = magic_ok_q;
        wide_d     = wide_q;
        buttons_d  = buttons_q;
        timeout_d  = 1'b0;
        dly_load   = 1'b0;
        dly_value  = SETTLE_LD;
        wr_ready   = 1'b0;

        case (state_q)
            // The settle wait only starts once 00 is actually on the bus.
            ST_MAGIC: begin
                if (ctl_q != CTL_MAGIC) begin
                    ctl_d    = CTL_MAGIC;
                    dly_load = 1'b1;
                end else if (dly_done) begin
                    magic_ok_d = (gp_in == CORE_MAGIC);
                    ctl_d      = CTL_IDLE;
                    state_d    = ST_IDLE;
                end
            end
            ST_IDLE: begin
                buttons_d = gp_in[30:29];
                if (core_rst_req) begin
                    ctl_d     = CTL_RST;
                    dly_value = RST_LD;
                    dly_load  = 1'b1;
                    state_d   = ST_RST;
                end else if (start && (sel != 2'd3)) begin
                    chan_d   = chan_onehot(sel);
                    first_d  = 1'b1;
                    dly_load = 1'b1;
                    state_d  = ST_OPEN;
                end
            end
            ST_OPEN: begin
                if (dly_done) begin
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                wr_ready = wr_valid;
                if (wr_valid) begin
                    din_d   = wr_data;
                    last_d  = wr_last;
                    state_d = ST_CLKHI;
                end
            end
            ST_CLKHI: begin
                io_clk_d = 1'b1;
                state_d  = ST_ACK1;
`ifdef HPS_IO_MASTER_TIMEOUT_EN
                dly_value = TIMEOUT_LD;
                dly_load  = 1'b1;
`endif
            end
            ST_ACK1: begin
                if (gp_in[GP_ACK]) begin
                    rd_data_d  = gp_in[15:0];
                    rd_valid_d = 1'b1;
                    if (first_q) begin
                        wide_d  = gp_in[GP_WIDE];
                        first_d = 1'b0;
                    end
                    io_clk_d = 1'b0;
                    state_d  = ST_ACK0;
`ifdef HPS_IO_MASTER_TIMEOUT_EN
                    dly_value = TIMEOUT_LD;
                    dly_load  = 1'b1;
                end else if (dly_done) begin
                    timeout_d = 1'b1;
                    io_clk_d  = 1'b0;
                    chan_d    = 3'b000;
                    din_d     = 16'd0;
                    dly_load  = 1'b1;
                    state_d   = ST_END;
`endif
                end
            end
            // Next io_clk rise waits for ack low so the responder sees one strobe per word.
            ST_ACK0: begin
                if (!gp_in[GP_ACK]) begin
                    if (last_q) begin
                        chan_d   = 3'b000;
                        din_d    = 16'd0;
                        dly_load = 1'b1;
                        state_d  = ST_END;
                    end else begin
                        state_d = ST_SEND;
                    end
`ifdef HPS_IO_MASTER_TIMEOUT_EN
                end else if (dly_done) begin
                    timeout_d = 1'b1;
                    io_clk_d  = 1'b0;
                    chan_d    = 3'b000;
                    din_d     = 16'd0;
                    dly_load  = 1'b1;
                    state_d   = ST_END;
`endif
                end
            end
            ST_END: begin
                if (dly_done) begin
                    state_d = ST_IDLE;
                end
            end
            // Two phases told apart by the control code currently driven: 01 hold, then 00 settle.
            ST_RST: begin
                if (dly_done) begin
                    if (ctl_q == CTL_RST) begin
                        ctl_d    = CTL_MAGIC;
                        dly_load = 1'b1;
                    end else begin
                        ctl_d   = CTL_IDLE;
                        state_d = ST_MAGIC;
                    end
                end
            end
            default: begin
                state_d = ST_MAGIC;
            end
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q    <= ST_MAGIC;
            ctl_q      <= CTL_IDLE;
            chan_q     <= 3'b000;
            io_clk_q   <= 1'b0;
            din_q      <= 16'd0;
            last_q     <= 1'b0;
            first_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            magic_ok_q <= 1'b0;
            wide_q     <= 1'b0;
            buttons_q  <= 2'b00;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctl_q      <= ctl_d;
            chan_q     <= chan_d;
            io_clk_q   <= io_clk_d;
            din_q      <= din_d;
            last_q     <= last_d;
            first_q    <= first_d;
            rd_valid_q <= rd_valid_d;
            magic_ok_q <= magic_ok_d;
            wide_q     <= wide_d;
            buttons_q  <= buttons_d;
            timeout_q  <= timeout_d;
        end
    end

    always_ff @(posedge clk_sys) begin
        rd_data_q <= rd_data_d;
    end

    assign gp_out   = {ctl_q, 9'd0, chan_q, io_clk_q, 1'b0, din_q};
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign busy     = (state_q != ST_IDLE);
    assign magic_ok = magic_ok_q;
    assign wide     = wide_q;
    assign buttons  = buttons_q;
`ifdef HPS_IO_MASTER_TIMEOUT_EN
    assign timeout  = timeout_q;
`else
    logic unused_timeout_q;
    assign unused_timeout_q = timeout_q;
`endif

endmodule

// File: tb/tb_hps_io_master.sv
// Bench for hps_io_master: responder model with a 2-flop gp_out pipe, registered io_ack,
// io_wait stall control and magic mux; directed scenarios each checked inline.
module tb_hps_io_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] gp_in;
    logic [31:0] gp_out;
    logic        start = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [15:0] wr_data = 16'd0;
    logic        wr_valid = 1'b0;
    logic        wr_last = 1'b0;
    logic        wr_ready;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        core_rst_req = 1'b0;
    logic        busy;
    logic        magic_ok;
    logic        wide;
    logic [1:0]  buttons;
`ifdef HPS_IO_MASTER_TIMEOUT_EN
    logic        timeout;
`endif

    int checks = 0;
    int errors = 0;

    // Responder model state and controls
    logic [31:0] p1 = '0;
    logic [31:0] p2 = '0;
    logic [1:0]  ctl_prev = 2'b00;
    logic        io_ack = 1'b0;
    logic        io_wait = 1'b0;
    logic        io_wide = 1'b1;
    logic [15:0] io_dout = 16'h1234;
    logic        btn_user = 1'b1;
    logic        btn_osd = 1'b0;
    logic        bad_magic = 1'b0;
    logic        core_rst = 1'b0;
    logic        core_rst_seen = 1'b0;
    int          strobes = 0;
    int          rd_cnt = 0;
    logic [15:0] sdin[$];
    logic [15:0] rdq[$];
    int          cyc = 0;
    logic        prev_clk = 1'b0;
    logic [15:0] prev_din = 16'd0;
    logic        prev_uio = 1'b0;
    logic        prev_ack = 1'b0;
    int          uio_fall_cyc = 0;
    int          ack_low_cyc = 0;
    int          onehot_viol = 0;
    int          din_viol = 0;
    int          push_fail = 0;

    always #5 clk = ~clk;

    assign gp_in = p2[31] ? {1'b0, btn_user, btn_osd, 9'd0, 2'b01, io_ack, io_wide, io_dout}
                          : (bad_magic ? 32'hDEAD_BEEF : 32'h5CA6_23A4);

`ifdef HPS_IO_MASTER_TIMEOUT_EN
    hps_io_master #(.SETTLE(4), .RST_HOLD(16), .TIMEOUT(100)) dut (
`else
    hps_io_master #(.SETTLE(4), .RST_HOLD(16), .TIMEOUT(65535)) dut (
`endif
        .clk_sys      (clk),
        .reset        (reset),
        .gp_in        (gp_in),
        .gp_out       (gp_out),
        .start        (start),
        .sel          (sel),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_last      (wr_last),
        .wr_ready     (wr_ready),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .core_rst_req (core_rst_req),
        .busy         (busy),
        .magic_ok     (magic_ok),
        .wide         (wide),
        .buttons      (buttons)
`ifdef HPS_IO_MASTER_TIMEOUT_EN
        ,
        .timeout      (timeout)
`endif
    );

    // Responder: strobe on io_clk rise seen through the pipe, held off while io_wait is set.
    always @(posedge clk) begin
        p1 <= gp_out;
        p2 <= p1;
        cyc <= cyc + 1;
        if (p2[31:30] == 2'b01) begin
            core_rst <= 1'b1;
            core_rst_seen <= 1'b1;
        end else if (ctl_prev == 2'b00 && p2[31:30] == 2'b10) begin
            core_rst <= 1'b0;
        end
        ctl_prev <= p2[31:30];
        if (p2[20:18] == 3'b000) begin
            io_ack <= 1'b0;
        end else if (p2[17] && !io_ack && !io_wait) begin
            io_ack <= 1'b1;
            strobes <= strobes + 1;
            sdin.push_back(p2[15:0]);
        end else if (!p2[17]) begin
            io_ack <= 1'b0;
        end
        if (rd_valid) begin
            rd_cnt <= rd_cnt + 1;
            rdq.push_back(rd_data);
        end
        if (!reset) begin
            if ($countones(gp_out[20:18]) > 1) onehot_viol <= onehot_viol + 1;
            if (prev_clk && gp_out[17] && gp_out[15:0] != prev_din) din_viol <= din_viol + 1;
        end
        if (prev_uio && !gp_out[20]) uio_fall_cyc <= cyc;
        if (prev_ack && !gp_in[17]) ack_low_cyc <= cyc;
        prev_clk <= gp_out[17];
        prev_din <= gp_out[15:0];
        prev_uio <= gp_out[20];
        prev_ack <= gp_in[17];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic open_frame(input logic [1:0] ch);
        start = 1'b1;
        sel = ch;
        tick();
        start = 1'b0;
    endtask

    task automatic push_word(input logic [15:0] d, input logic last);
        logic ok;
        ok = 1'b0;
        wr_data = d;
        wr_last = last;
        wr_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            #1;
            if (wr_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        wr_last = 1'b0;
        if (!ok) push_fail++;
    endtask

    task automatic wait_idle(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wr_valid = 1'b1;
        repeat (3) tick();
        checks++; if (gp_out !== 32'h8000_0000) begin errors++; $display("FAIL rst_gp_out got %h want 80000000", gp_out); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_busy got %b want 1", busy); end
        checks++; if (magic_ok !== 1'b0) begin errors++; $display("FAIL rst_magic_ok got %b want 0", magic_ok); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL rst_rd_valid got %b want 0", rd_valid); end
        checks++; if (wr_ready !== 1'b0) begin errors++; $display("FAIL rst_wr_ready got %b want 0", wr_ready); end
        checks++; if (wide !== 1'b0) begin errors++; $display("FAIL rst_wide got %b want 0", wide); end
        checks++; if (buttons !== 2'b00) begin errors++; $display("FAIL rst_buttons got %b want 00", buttons); end
        wr_valid = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 6 && busy; i++) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL boot_busy got %b want 0", busy); end
        checks++; if (magic_ok !== 1'b1) begin errors++; $display("FAIL boot_magic_ok got %b want 1", magic_ok); end
        checks++; if (gp_out !== 32'h8000_0000) begin errors++; $display("FAIL boot_gp_out got %h want 80000000", gp_out); end
    endtask

    task automatic test_uio_frame();
        int sb, rb, pf, c0;
        logic ok;
        repeat (5) tick();
        checks++; if (buttons !== 2'b10) begin errors++; $display("FAIL buttons got %b want 10", buttons); end
        sb = strobes; rb = rd_cnt; pf = push_fail; c0 = cyc;
        io_dout = 16'h1234;
        io_wide = 1'b1;
        open_frame(2'd0);
        push_word(16'h0001, 1'b0);
        push_word(16'h00A5, 1'b1);
        wait_idle(ok);
        checks++; if (!ok || push_fail != pf) begin errors++; $display("FAIL uio_complete got idle=%b stalls=%0d want idle=1 stalls=0", ok, push_fail - pf); end
        checks++; if (strobes - sb != 2) begin errors++; $display("FAIL uio_strobes got %0d want 2", strobes - sb); end
        if (strobes - sb == 2) begin
            checks++; if (sdin[sb] !== 16'h0001) begin errors++; $display("FAIL uio_din0 got %h want 0001", sdin[sb]); end
            checks++; if (sdin[sb+1] !== 16'h00A5) begin errors++; $display("FAIL uio_din1 got %h want 00a5", sdin[sb+1]); end
        end
        checks++; if (rd_cnt - rb != 2) begin errors++; $display("FAIL uio_rd_count got %0d want 2", rd_cnt - rb); end
        if (rd_cnt - rb == 2) begin
            checks++; if (rdq[rb] !== 16'h1234 || rdq[rb+1] !== 16'h1234) begin errors++; $display("FAIL uio_rd_data got %h %h want 1234 1234", rdq[rb], rdq[rb+1]); end
        end
        checks++; if (!(uio_fall_cyc > ack_low_cyc && ack_low_cyc > c0)) begin errors++; $display("FAIL uio_fall_order got fall=%0d ack_low=%0d want fall>ack_low>%0d", uio_fall_cyc, ack_low_cyc, c0); end
        checks++; if (wide !== 1'b1) begin errors++; $display("FAIL uio_wide got %b want 1", wide); end
        checks++; if (gp_out !== 32'h8000_0000) begin errors++; $display("FAIL uio_end_gp_out got %h want 80000000", gp_out); end
    endtask

    task automatic test_osd_wait();
        int sb, rb, pf, clk_drop;
        logic ok;
        sb = strobes; rb = rd_cnt; pf = push_fail; clk_drop = 0;
        io_dout = 16'hBEEF;
        io_wide = 1'b0;
        open_frame(2'd2);
        io_wait = 1'b1;
        push_word(16'h0011, 1'b0);
        repeat (3) tick();
        for (int i = 0; i < 50; i++) begin
            if (!gp_out[17]) clk_drop++;
            tick();
        end
        checks++; if (clk_drop != 0) begin errors++; $display("FAIL osd_clk_held got %0d low cycles want 0", clk_drop); end
        checks++; if (strobes - sb != 0) begin errors++; $display("FAIL osd_stall_strobes got %0d want 0", strobes - sb); end
        checks++; if (rd_cnt - rb != 0) begin errors++; $display("FAIL osd_stall_rd got %0d want 0", rd_cnt - rb); end
        checks++; if (gp_out[20:18] !== 3'b010) begin errors++; $display("FAIL osd_select got %b want 010", gp_out[20:18]); end
        io_wait = 1'b0;
        repeat (20) tick();
        checks++; if (rd_cnt - rb != 1 || strobes - sb != 1) begin errors++; $display("FAIL osd_release got rd=%0d strobes=%0d want 1 1", rd_cnt - rb, strobes - sb); end
        if (rd_cnt - rb == 1) begin
            checks++; if (rdq[rb] !== 16'hBEEF) begin errors++; $display("FAIL osd_rd_data got %h want beef", rdq[rb]); end
        end
        push_word(16'h0022, 1'b1);
        wait_idle(ok);
        checks++; if (!ok || push_fail != pf) begin errors++; $display("FAIL osd_complete got idle=%b stalls=%0d want idle=1 stalls=0", ok, push_fail - pf); end
        checks++; if (strobes - sb != 2) begin errors++; $display("FAIL osd_strobes got %0d want 2", strobes - sb); end
        if (strobes - sb == 2) begin
            checks++; if (sdin[sb] !== 16'h0011 || sdin[sb+1] !== 16'h0022) begin errors++; $display("FAIL osd_din got %h %h want 0011 0022", sdin[sb], sdin[sb+1]); end
        end
        checks++; if (wide !== 1'b0) begin errors++; $display("FAIL osd_wide got %b want 0", wide); end
    endtask

    task automatic test_core_reset();
        logic [1:0] smp[30];
        logic [1:0] rv[4];
        int         rl[4];
        int         nr;
        logic       ok;
        bad_magic = 1'b1;
        core_rst_req = 1'b1;
        tick();
        core_rst_req = 1'b0;
        for (int i = 0; i < 30; i++) begin
            smp[i] = gp_out[31:30];
            tick();
        end
        nr = 0;
        rv[0] = smp[0]; rl[0] = 0;
        for (int i = 0; i < 30; i++) begin
            if (smp[i] != rv[nr]) begin
                if (nr == 3) break;
                nr++;
                rv[nr] = smp[i];
                rl[nr] = 0;
            end
            rl[nr]++;
        end
        checks++; if (rv[0] !== 2'b01 || rl[0] != 16) begin errors++; $display("FAIL rst_hold got %b x%0d want 01 x16", rv[0], rl[0]); end
        checks++; if (nr < 2 || rv[1] !== 2'b00 || rl[1] != 4) begin errors++; $display("FAIL rst_settle got %b x%0d want 00 x4", rv[1], rl[1]); end
        checks++; if (nr < 2 || rv[2] !== 2'b10) begin errors++; $display("FAIL rst_release got %b want 10", rv[2]); end
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rst_idle got busy=%b want 0", busy); end
        checks++; if (core_rst_seen !== 1'b1 || core_rst !== 1'b0) begin errors++; $display("FAIL rst_model got seen=%b active=%b want 1 0", core_rst_seen, core_rst); end
        checks++; if (magic_ok !== 1'b0) begin errors++; $display("FAIL rst_recheck got %b want 0", magic_ok); end
        bad_magic = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int sb, rb, pf;
        logic ok;
        io_dout = 16'h1234;
        io_wide = 1'b1;
        sb = strobes; rb = rd_cnt; pf = push_fail;
        open_frame(2'd0);
        io_wait = 1'b1;
        push_word(16'h7777, 1'b1);
        repeat (8) tick();
        checks++; if (gp_out[17] !== 1'b1) begin errors++; $display("FAIL mid_in_ack1 got io_clk=%b want 1", gp_out[17]); end
        reset = 1'b1;
        tick();
        checks++; if (gp_out !== 32'h8000_0000) begin errors++; $display("FAIL mid_gp_out got %h want 80000000", gp_out); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL mid_rd_valid got %b want 0", rd_valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
        repeat (3) tick();
        io_wait = 1'b0;
        reset = 1'b0;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_reboot got busy=%b want 0", busy); end
        checks++; if (strobes - sb != 0 || rd_cnt - rb != 0) begin errors++; $display("FAIL mid_partial got strobes=%0d rd=%0d want 0 0", strobes - sb, rd_cnt - rb); end
        checks++; if (magic_ok !== 1'b1) begin errors++; $display("FAIL mid_magic got %b want 1", magic_ok); end
        sb = strobes; rb = rd_cnt;
        open_frame(2'd1);
        push_word(16'h5A5A, 1'b1);
        wait_idle(ok);
        checks++; if (!ok || push_fail != pf) begin errors++; $display("FAIL fpga_complete got idle=%b stalls=%0d want idle=1 stalls=0", ok, push_fail - pf); end
        checks++; if (strobes - sb != 1) begin errors++; $display("FAIL fpga_strobes got %0d want 1", strobes - sb); end
        if (strobes - sb == 1) begin
            checks++; if (sdin[sb] !== 16'h5A5A) begin errors++; $display("FAIL fpga_din got %h want 5a5a", sdin[sb]); end
        end
        checks++; if (rd_cnt - rb != 1) begin errors++; $display("FAIL fpga_rd_count got %0d want 1", rd_cnt - rb); end
        if (rd_cnt - rb == 1) begin
            checks++; if (rdq[rb] !== 16'h1234) begin errors++; $display("FAIL fpga_rd_data got %h want 1234", rdq[rb]); end
        end
        checks++; if (gp_out !== 32'h8000_0000) begin errors++; $display("FAIL fpga_end_gp_out got %h want 80000000", gp_out); end
    endtask

`ifdef HPS_IO_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        int rb;
        logic found, ok;
        rb = rd_cnt;
        found = 1'b0;
        io_wait = 1'b1;
        open_frame(2'd0);
        push_word(16'h0101, 1'b1);
        for (int i = 0; i < 300; i++) begin
            if (timeout) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        checks++; if (!found) begin errors++; $display("FAIL to_pulse got none want pulse"); end
        checks++; if (gp_out[20] !== 1'b0 || gp_out[17] !== 1'b0) begin errors++; $display("FAIL to_drop got uio=%b clk=%b want 0 0", gp_out[20], gp_out[17]); end
        tick();
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL to_width got %b want 0", timeout); end
        io_wait = 1'b0;
        wait_idle(ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_idle got busy=%b want 0", busy); end
        checks++; if (rd_cnt != rb) begin errors++; $display("FAIL to_rd got %0d want 0", rd_cnt - rb); end
    endtask
`endif

    task automatic test_protocol();
        checks++; if (onehot_viol != 0) begin errors++; $display("FAIL onehot_select got %0d violations want 0", onehot_viol); end
        checks++; if (din_viol != 0) begin errors++; $display("FAIL din_stable got %0d violations want 0", din_viol); end
    endtask

    initial begin
        test_reset();
        test_uio_frame();
        test_osd_wait();
        test_core_reset();
        test_reset_mid_frame();
`ifdef HPS_IO_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_protocol();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
